mem_dp: RTL and testbench
=========================

# mem_dp

Parametrised dual-port synchronous RAM that succeeds the single-port data memory. Port A reads and writes with per-lane write enables. Port B is read-only. A built-in clear sequencer zeroes the array after reset or on request, and a ready flag gates both ports while the clear runs. The block sits between the execute/memory stage (port A) and the fetch or debug path (port B).

## Interface
Parameters:
- DATA_W, 24, word width in bits; must be a multiple of LANE_W
- LANE_W, 8, write-enable lane width; LANES = DATA_W/LANE_W
- ADDR_W, 12, address width; DEPTH = 2**ADDR_W
- RDW_MODE, 0, read-during-write on the same address: 0 = old data, 1 = new (merged) data

Ports:
- iw_clk  in  1  clock; all logic on rising edge
- iw_rst_n  in  1  reset, synchronous, active-low
- iw_clr  in  1  one-cycle pulse; restarts the clear sequence
- or_ready  out  1  high when ports accept requests
- iw_en_a  in  1  port A request
- iw_we_a  in  LANES  port A lane write enables (any bit set = write)
- iw_addr_a  in  ADDR_W  port A address
- iw_wdata_a  in  DATA_W  port A write data
- or_rdata_a  out  DATA_W  port A read data
- or_rvalid_a  out  1  port A read data valid
- iw_en_b  in  1  port B read request
- iw_addr_b  in  ADDR_W  port B address
- or_rdata_b  out  DATA_W  port B read data
- or_rvalid_b  out  1  port B read data valid

## Operation
- The FSM has two states, CLEAR and READY.
- Reset (iw_rst_n low at an edge) puts the FSM in CLEAR with clear counter = 0. All outputs go to 0 (or_ready=0, rvalid=0, rdata=0).
- CLEAR:
  - each cycle writes 0 to mem[counter], then increments the counter.
  - after writing DEPTH-1 the FSM moves to READY; the counter wraps to 0.
  - iw_en_a and iw_en_b are ignored and produce no rvalid.
- READY:
  - or_ready=1.
  - iw_clr=1 moves the FSM to CLEAR with counter=0 on the next edge. A request presented in that same cycle is still serviced.
  - iw_clr during CLEAR restarts the counter at 0.
- Port A with iw_en_a=1:
  - each lane i with iw_we_a[i]=1 writes bits [i*LANE_W +: LANE_W]; the other lanes keep their value.
  - or_rdata_a returns the word per RDW_MODE: old contents in mode 0; old contents with the written lanes replaced in mode 1.
  - or_rvalid_a=1 for every request, reads and writes alike.
- Port B with iw_en_b=1: reads mem[iw_addr_b].
  - If port A writes the same address in the same cycle, the RDW_MODE rule applies to port B as well.
  - Different addresses never interact.
- With no request, or_rdata_x holds its last value and or_rvalid_x=0.
- Reset asserted mid-clear or mid-operation aborts everything. Array contents are undefined until the new clear completes.

## Timing
- Read latency is 1 cycle: a request at edge N gives rdata/rvalid valid after edge N+1 for one cycle.
- A write is visible to any read issued on a later cycle.
- Clear takes exactly DEPTH cycles: or_ready rises after the DEPTH-th edge following reset release or the iw_clr pulse.
- There is no backpressure: in READY, requests are accepted every cycle on both ports.
- Mode 1 merge: the output-stage bypass registers the write data, mask and an address-match flag. It adds no latency.

## Structure
- The shared sizes header holds the FSM state encodings (ST_CLEAR, ST_READY) and the defaults for DATA_W, LANE_W and ADDR_W.
- Lane-mask expansion (LANES bits -> DATA_W mask) is a function in the same header.
- One sub-module, mem_dp_clr: the clear sequencer (FSM, counter, or_ready, clear-address/write mux).
- The array and port logic live in mem_dp and must infer a true dual-port block RAM.

## Test plan
- Reset then run: or_ready=0 for 4096 cycles, then 1. Reads of addresses 0, 2048 and 4095 return 0 with rvalid one cycle later.
- Lane write: write 0xAABBCC to addr 5 with we=3'b111, then 0x112233 with we=3'b010. Reading addr 5 returns 0xAA22CC.
- RDW_MODE=0, word 0x000000: A writes 0x123456 to addr 7 (we=111) while B reads addr 7. Both rdata=0x000000; a following read returns 0x123456.
- RDW_MODE=1, word 0xAABBCC: A writes 0x112233 we=001 to addr 9 while B reads addr 9. Both return 0xAABB33.
- While ready, pulse iw_clr with a pending write to addr 3. The write lands, or_ready drops next cycle, requests during clear give no rvalid, and after 4096 cycles addr 3 reads 0.
- Assert iw_rst_n low at clear counter 1000: all outputs 0 next edge. After release the clear restarts and takes a full 4096 cycles.

Source files
------------

// File: rtl/mem_dp_pkg.sv
// Shared sizes, FSM encodings and the lane-mask helper for the dual-port data memory.
package mem_dp_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 24;
    localparam int LANE_W_DEF = 8;
    localparam int ADDR_W_DEF = 12;

    // Upper bounds for the mask helper; callers cast the result down to DATA_W.
    localparam int MAX_LANES  = 32;
    localparam int MAX_DATA_W = 256;

    function automatic logic [MAX_DATA_W-1:0] lane_mask(
        input logic [MAX_LANES-1:0] we,
        input int                   lanes,
        input int                   lane_w
    );
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if ((i / lane_w) < lanes) begin
                m[i] = we[i / lane_w];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_dp_clr.sv
// Clear sequencer: zeroes the array after reset or iw_clr, gates both ports and
// muxes the clear address/data onto the port A write path.
module mem_dp_clr
    import mem_dp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = DATA_W_DEF / LANE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_en_a,
    input  logic [LANES-1:0]  i_we_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [DATA_W-1:0] i_wdata_a,
    input  logic              i_en_b,
    output logic              o_ready,
    output logic              o_acc_a,
    output logic              o_acc_b,
    output logic [LANES-1:0]  o_wr_we,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (&cnt_q) begin
                    state_d = ST_READY;
                end
                if (i_clr) begin
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_READY: begin
                if (i_clr) begin
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Requests are honoured in READY even in the cycle iw_clr is seen.
    always_comb begin
        o_ready   = (state_q == ST_READY);
        o_acc_a   = o_ready && i_en_a;
        o_acc_b   = o_ready && i_en_b;
        o_wr_we   = o_acc_a ? i_we_a : '0;
        o_wr_addr = i_addr_a;
        o_wr_data = i_wdata_a;
        if (!o_ready) begin
            o_wr_we   = '1;
            o_wr_addr = cnt_q;
            o_wr_data = '0;
        end
    end

endmodule

// File: rtl/mem_dp.sv
// Dual-port synchronous RAM: port A read/write with lane enables, port B read-only,
// built-in clear sequencer and optional write-through (merged) read-during-write.
module mem_dp
    import mem_dp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LANE_W   = LANE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RDW_MODE = 0
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst_n,
    input  logic                     iw_clr,
    output logic                     or_ready,
    input  logic                     iw_en_a,
    input  logic [DATA_W/LANE_W-1:0] iw_we_a,
    input  logic [ADDR_W-1:0]        iw_addr_a,
    input  logic [DATA_W-1:0]        iw_wdata_a,
    output logic [DATA_W-1:0]        or_rdata_a,
    output logic                     or_rvalid_a,
    input  logic                     iw_en_b,
    input  logic [ADDR_W-1:0]        iw_addr_b,
    output logic [DATA_W-1:0]        or_rdata_b,
    output logic                     or_rvalid_b
);

    localparam int LANES = DATA_W / LANE_W;
    localparam int DEPTH = 1 << ADDR_W;

    logic              acc_a, acc_b;
    logic [LANES-1:0]  wr_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    mem_dp_clr #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_clr (
        .i_clk     (iw_clk),
        .i_rst_n   (iw_rst_n),
        .i_clr     (iw_clr),
        .i_en_a    (iw_en_a),
        .i_we_a    (iw_we_a),
        .i_addr_a  (iw_addr_a),
        .i_wdata_a (iw_wdata_a),
        .i_en_b    (iw_en_b),
        .o_ready   (or_ready),
        .o_acc_a   (acc_a),
        .o_acc_b   (acc_b),
        .o_wr_we   (wr_we),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_a_q, ram_b_q;

    // Read-first on both ports; mode 1 merging happens in the output stage.
    always_ff @(posedge iw_clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_we[i]) begin
                mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
            end
        end
        if (acc_a) begin
            ram_a_q <= mem[wr_addr];
        end
    end

    always_ff @(posedge iw_clk) begin
        if (acc_b) begin
            ram_b_q <= mem[iw_addr_b];
        end
    end

    logic [DATA_W-1:0] wmask;
    logic              wr_any;
    logic              rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic              live_a_q, live_a_d, live_b_q, live_b_d;
    logic              hit_a_q, hit_a_d, hit_b_q, hit_b_d;
    logic [DATA_W-1:0] byp_mask_a_q, byp_mask_a_d, byp_data_a_q, byp_data_a_d;
    logic [DATA_W-1:0] byp_mask_b_q, byp_mask_b_d, byp_data_b_q, byp_data_b_d;

    // Each port keeps its own bypass copy so a held output stays stable.
    always_comb begin
        wmask        = DATA_W'(lane_mask(MAX_LANES'(iw_we_a), LANES, LANE_W));
        wr_any       = |iw_we_a;
        rvalid_a_d   = acc_a;
        rvalid_b_d   = acc_b;
        live_a_d     = live_a_q || acc_a;
        live_b_d     = live_b_q || acc_b;
        hit_a_d      = hit_a_q;
        hit_b_d      = hit_b_q;
        byp_mask_a_d = byp_mask_a_q;
        byp_data_a_d = byp_data_a_q;
        byp_mask_b_d = byp_mask_b_q;
        byp_data_b_d = byp_data_b_q;
        if (acc_a) begin
            hit_a_d      = (RDW_MODE == 1) && wr_any;
            byp_mask_a_d = wmask;
            byp_data_a_d = iw_wdata_a;
        end
        if (acc_b) begin
            hit_b_d      = (RDW_MODE == 1) && acc_a && wr_any && (iw_addr_a == iw_addr_b);
            byp_mask_b_d = wmask;
            byp_data_b_d = iw_wdata_a;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            live_a_q   <= 1'b0;
            live_b_q   <= 1'b0;
            hit_a_q    <= 1'b0;
            hit_b_q    <= 1'b0;
        end else begin
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            live_a_q   <= live_a_d;
            live_b_q   <= live_b_d;
            hit_a_q    <= hit_a_d;
            hit_b_q    <= hit_b_d;
        end
    end

    always_ff @(posedge iw_clk) begin
        byp_mask_a_q <= byp_mask_a_d;
        byp_data_a_q <= byp_data_a_d;
        byp_mask_b_q <= byp_mask_b_d;
        byp_data_b_q <= byp_data_b_d;
    end

    always_comb begin
        or_rvalid_a = rvalid_a_q;
        or_rvalid_b = rvalid_b_q;
        or_rdata_a  = '0;
        or_rdata_b  = '0;
        if (live_a_q) begin
            or_rdata_a = hit_a_q ? ((ram_a_q & ~byp_mask_a_q) | (byp_data_a_q & byp_mask_a_q))
                                 : ram_a_q;
        end
        if (live_b_q) begin
            or_rdata_b = hit_b_q ? ((ram_b_q & ~byp_mask_b_q) | (byp_data_b_q & byp_mask_b_q))
                                 : ram_b_q;
        end
    end

endmodule

// File: tb/tb_mem_dp.sv
// Directed bench for mem_dp: one instance per read-during-write mode, driven in lockstep.
module tb_mem_dp;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n, clr;
    logic        en_a, en_b;
    logic [2:0]  we_a;
    logic [11:0] addr_a, addr_b;
    logic [23:0] wdata_a;

    logic        rdy0, rva0, rvb0, rdy1, rva1, rvb1;
    logic [23:0] rda0, rdb0, rda1, rdb1;

    always #5 clk = ~clk;

    mem_dp #(.DATA_W(24), .LANE_W(8), .ADDR_W(12), .RDW_MODE(0)) dut0 (
        .iw_clk(clk), .iw_rst_n(rst_n), .iw_clr(clr), .or_ready(rdy0),
        .iw_en_a(en_a), .iw_we_a(we_a), .iw_addr_a(addr_a), .iw_wdata_a(wdata_a),
        .or_rdata_a(rda0), .or_rvalid_a(rva0),
        .iw_en_b(en_b), .iw_addr_b(addr_b), .or_rdata_b(rdb0), .or_rvalid_b(rvb0)
    );

    mem_dp #(.DATA_W(24), .LANE_W(8), .ADDR_W(12), .RDW_MODE(1)) dut1 (
        .iw_clk(clk), .iw_rst_n(rst_n), .iw_clr(clr), .or_ready(rdy1),
        .iw_en_a(en_a), .iw_we_a(we_a), .iw_addr_a(addr_a), .iw_wdata_a(wdata_a),
        .or_rdata_a(rda1), .or_rvalid_a(rva1),
        .iw_en_b(en_b), .iw_addr_b(addr_b), .or_rdata_b(rdb1), .or_rvalid_b(rvb1)
    );

    typedef struct {
        logic        en_a;
        logic [2:0]  we;
        logic [11:0] addr_a;
        logic [23:0] wdata;
        logic        en_b;
        logic [11:0] addr_b;
        logic        va;
        logic        vb;
        logic [23:0] a0;
        logic [23:0] a1;
        logic [23:0] b0;
        logic [23:0] b1;
    } vec_t;

    vec_t vecs [13];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic va, input logic [23:0] a0,
                           input logic [23:0] a1, input logic vb, input logic [23:0] b0,
                           input logic [23:0] b1);
        chk($sformatf("%s rvalid_a", nm), {30'd0, rva0, rva1}, {30'd0, va, va});
        chk($sformatf("%s rvalid_b", nm), {30'd0, rvb0, rvb1}, {30'd0, vb, vb});
        chk($sformatf("%s rdata_a m0", nm), {8'd0, rda0}, {8'd0, a0});
        chk($sformatf("%s rdata_a m1", nm), {8'd0, rda1}, {8'd0, a1});
        chk($sformatf("%s rdata_b m0", nm), {8'd0, rdb0}, {8'd0, b0});
        chk($sformatf("%s rdata_b m1", nm), {8'd0, rdb1}, {8'd0, b1});
    endtask

    task automatic idle_inputs();
        clr = 1'b0; en_a = 1'b0; we_a = 3'b000; addr_a = '0; wdata_a = '0;
        en_b = 1'b0; addr_b = '0;
    endtask

    // Counts DEPTH edges; ready must stay low until the last one and no rvalid may appear.
    task automatic wait_clear(input string nm);
        int early = 0;
        int vld   = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk);
            #1;
            if (i < DEPTH && (rdy0 || rdy1)) early++;
            if (rva0 || rva1 || rvb0 || rvb1) vld++;
        end
        chk($sformatf("%s ready low", nm), early, 0);
        chk($sformatf("%s no rvalid", nm), vld, 0);
        chk($sformatf("%s ready high", nm), {30'd0, rdy0, rdy1}, 32'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 3'b000, 12'd0,    24'h000000, 1'b1, 12'd2048, 1'b1, 1'b1, 24'h000000, 24'h000000, 24'h000000, 24'h000000};
        vecs[1]  = '{1'b1, 3'b000, 12'd4095, 24'h000000, 1'b1, 12'd0,    1'b1, 1'b1, 24'h000000, 24'h000000, 24'h000000, 24'h000000};
        vecs[2]  = '{1'b1, 3'b111, 12'd5,    24'hAABBCC, 1'b0, 12'd0,    1'b1, 1'b0, 24'h000000, 24'hAABBCC, 24'h000000, 24'h000000};
        vecs[3]  = '{1'b1, 3'b010, 12'd5,    24'h112233, 1'b0, 12'd0,    1'b1, 1'b0, 24'hAABBCC, 24'hAA22CC, 24'h000000, 24'h000000};
        vecs[4]  = '{1'b1, 3'b000, 12'd5,    24'h000000, 1'b1, 12'd5,    1'b1, 1'b1, 24'hAA22CC, 24'hAA22CC, 24'hAA22CC, 24'hAA22CC};
        vecs[5]  = '{1'b1, 3'b111, 12'd7,    24'h123456, 1'b1, 12'd7,    1'b1, 1'b1, 24'h000000, 24'h123456, 24'h000000, 24'h123456};
        vecs[6]  = '{1'b1, 3'b000, 12'd7,    24'h000000, 1'b1, 12'd7,    1'b1, 1'b1, 24'h123456, 24'h123456, 24'h123456, 24'h123456};
        vecs[7]  = '{1'b1, 3'b111, 12'd9,    24'hAABBCC, 1'b0, 12'd0,    1'b1, 1'b0, 24'h000000, 24'hAABBCC, 24'h123456, 24'h123456};
        vecs[8]  = '{1'b1, 3'b001, 12'd9,    24'h112233, 1'b1, 12'd9,    1'b1, 1'b1, 24'hAABBCC, 24'hAABB33, 24'hAABBCC, 24'hAABB33};
        vecs[9]  = '{1'b0, 3'b000, 12'd0,    24'h000000, 1'b0, 12'd0,    1'b0, 1'b0, 24'hAABBCC, 24'hAABB33, 24'hAABBCC, 24'hAABB33};
        vecs[10] = '{1'b1, 3'b100, 12'd10,   24'hFFFFFF, 1'b1, 12'd9,    1'b1, 1'b1, 24'h000000, 24'hFF0000, 24'hAABB33, 24'hAABB33};
        vecs[11] = '{1'b1, 3'b000, 12'd10,   24'h000000, 1'b1, 12'd10,   1'b1, 1'b1, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000};
        vecs[12] = '{1'b0, 3'b000, 12'd0,    24'h000000, 1'b1, 12'd5,    1'b0, 1'b1, 24'hFF0000, 24'hFF0000, 24'hAA22CC, 24'hAA22CC};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", {30'd0, rdy0, rdy1}, 32'd0);
        chk_all("reset", 1'b0, 24'h0, 24'h0, 1'b0, 24'h0, 24'h0);

        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("init clear");

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            en_a = vecs[i].en_a; we_a = vecs[i].we; addr_a = vecs[i].addr_a;
            wdata_a = vecs[i].wdata; en_b = vecs[i].en_b; addr_b = vecs[i].addr_b;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].va, vecs[i].a0, vecs[i].a1,
                    vecs[i].vb, vecs[i].b0, vecs[i].b1);
        end

        // iw_clr with a write in the same cycle: the write is serviced, then the clear runs.
        @(negedge clk);
        idle_inputs();
        clr = 1'b1; en_a = 1'b1; we_a = 3'b111; addr_a = 12'd3; wdata_a = 24'h5A5A5A;
        @(posedge clk);
        #1;
        chk("clr ready drop", {30'd0, rdy0, rdy1}, 32'd0);
        chk("clr write rvalid", {30'd0, rva0, rva1}, 32'd3);
        chk("clr write rdata m0", {8'd0, rda0}, 32'h000000);
        chk("clr write rdata m1", {8'd0, rda1}, 32'h5A5A5A);
        @(negedge clk);
        idle_inputs();
        en_a = 1'b1; addr_a = 12'd3; en_b = 1'b1; addr_b = 12'd3;
        wait_clear("clr clear");
        @(negedge clk);
        idle_inputs();
        en_a = 1'b1; addr_a = 12'd3; en_b = 1'b1; addr_b = 12'd5;
        @(posedge clk);
        #1;
        chk_all("post clr", 1'b1, 24'h0, 24'h0, 1'b1, 24'h0, 24'h0);

        // Reset in the middle of a clear.
        @(negedge clk);
        idle_inputs();
        en_a = 1'b1; we_a = 3'b111; addr_a = 12'd1; wdata_a = 24'hFFFFFF;
        @(negedge clk);
        idle_inputs();
        clr = 1'b1; en_a = 1'b1; addr_a = 12'd1; en_b = 1'b1; addr_b = 12'd1;
        @(posedge clk);
        #1;
        chk_all("read at clr", 1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
        @(negedge clk);
        idle_inputs();
        repeat (999) @(posedge clk);
        #1;
        chk_all("hold in clear", 1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'hFFFFFF, 24'hFFFFFF);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid-clear reset ready", {30'd0, rdy0, rdy1}, 32'd0);
        chk_all("mid-clear reset", 1'b0, 24'h0, 24'h0, 1'b0, 24'h0, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("reset clear");
        @(negedge clk);
        idle_inputs();
        en_a = 1'b1; addr_a = 12'd1; en_b = 1'b1; addr_b = 12'd4095;
        @(posedge clk);
        #1;
        chk_all("post reset", 1'b1, 24'h0, 24'h0, 1'b1, 24'h0, 24'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
